// File: rtl/if_stage_btb_param_if.sv
// Fetch-stage bus: EX redirect/training inputs, instruction-memory port and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is its environment.
interface if_stage_btb_param_if #(
    parameter int XLEN        = 32,
    parameter int IMEM_ADDR_W = 10
);
    logic                   pc_en;
    logic                   modify_pc_ex;
    logic [XLEN-1:0]        update_pc_ex;
    logic                   update_btb_ex;
    logic [XLEN-1:0]        btb_pc_ex;
    logic [XLEN-1:0]        jump_addr_ex;
    logic                   ex_branch_taken;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_rdata;
    logic [XLEN-1:0]        pc_if;
    logic [31:0]            instr_if;
    logic                   valid_if;
    logic                   predictedTaken_if;
    logic [XLEN-1:0]        predictedTarget_if;

    modport master (
        output pc_en, modify_pc_ex, update_pc_ex, update_btb_ex, btb_pc_ex,
               jump_addr_ex, ex_branch_taken, imem_rdata,
        input  imem_addr, pc_if, instr_if, valid_if, predictedTaken_if,
               predictedTarget_if
    );

    modport slave (
        input  pc_en, modify_pc_ex, update_pc_ex, update_btb_ex, btb_pc_ex,
               jump_addr_ex, ex_branch_taken, imem_rdata,
        output imem_addr, pc_if, instr_if, valid_if, predictedTaken_if,
               predictedTarget_if
    );
endinterface

// File: rtl/if_stage_btb_param.sv
// Instruction-fetch stage: PC register, direct-mapped BTB with saturating direction
// counters, next-PC selection and a zero-latency combinational instruction read.
module if_stage_btb_param #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter int              CTR_BITS    = 2,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              IMEM_ADDR_W = 10
) (
    input logic                 clk,
    input logic                 rst,
    if_stage_btb_param_if.slave bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [XLEN-1:0]     WORD_MSK = ~XLEN'(3);

    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]     btb_target [BTB_ENTRIES];
    logic [CTR_BITS-1:0] btb_ctr    [BTB_ENTRIES];

    logic [XLEN-1:0]  pc_q;
    logic             valid_q;
    logic [IDX-1:0]   l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  next_pc;
    logic [IDX-1:0]   u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             unused_ok;

    assign unused_ok = ^bus.btb_pc_ex[1:0];

    assign l_idx      = bus.pc_if[IDX+1:2];
    assign l_tag      = bus.pc_if[XLEN-1:IDX+2];
    assign l_hit      = btb_valid[l_idx] && (btb_tag[l_idx] == l_tag);
    assign pred_taken = l_hit && btb_ctr[l_idx][CTR_BITS-1];
    assign pc_plus4   = pc_q + XLEN'(4);

    assign bus.pc_if              = pc_q;
    assign bus.imem_addr          = pc_q[IMEM_ADDR_W+1:2];
    assign bus.instr_if           = bus.imem_rdata;
    assign bus.predictedTaken_if  = pred_taken;
    assign bus.predictedTarget_if = pred_taken ? btb_target[l_idx] : pc_plus4;
    // A redirect in flight means the instruction currently in IF is wrong-path.
    assign bus.valid_if           = valid_q && !bus.modify_pc_ex;

    always_comb begin
        next_pc = pc_q;
        if (bus.modify_pc_ex)  next_pc = bus.update_pc_ex;
        else if (!bus.pc_en)   next_pc = pc_q;
        else if (pred_taken)   next_pc = btb_target[l_idx];
        else                   next_pc = pc_plus4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC & WORD_MSK;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= next_pc & WORD_MSK;
            valid_q <= 1'b1;
        end
    end

    assign u_idx = bus.btb_pc_ex[IDX+1:2];
    assign u_tag = bus.btb_pc_ex[XLEN-1:IDX+2];
    assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= '0;
            end
        end else if (bus.update_btb_ex) begin
            if (u_hit) begin
                if (bus.ex_branch_taken) begin
                    if (btb_ctr[u_idx] != CTR_MAX) btb_ctr[u_idx] <= btb_ctr[u_idx] + CTR_BITS'(1);
                    btb_target[u_idx] <= bus.jump_addr_ex & WORD_MSK;
                end else if (btb_ctr[u_idx] != '0) begin
                    btb_ctr[u_idx] <= btb_ctr[u_idx] - CTR_BITS'(1);
                end
            end else if (bus.ex_branch_taken) begin
                // Allocation on a taken miss also evicts any aliasing entry.
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= bus.jump_addr_ex & WORD_MSK;
                btb_ctr[u_idx]    <= CTR_WEAK;
            end
        end
    end
endmodule

// File: tb/tb_if_stage_btb_param.sv
// Directed bench for if_stage_btb_param: one table row per clock cycle, outputs checked
// before the rising edge, followed by a mid-run reset sequence.
module tb_if_stage_btb_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    if_stage_btb_param_if #(.XLEN(32), .IMEM_ADDR_W(10)) bus ();

    if_stage_btb_param #(
        .XLEN(32), .BTB_ENTRIES(16), .CTR_BITS(2), .RESET_PC(32'h0), .IMEM_ADDR_W(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = 32'hA500_0000 | {22'b0, bus.imem_addr};

    typedef struct {
        logic        pc_en;
        logic        modify;
        logic [31:0] upd_pc;
        logic        upd_btb;
        logic [31:0] btb_pc;
        logic [31:0] jump;
        logic        taken;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_tk;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic en, logic md, logic [31:0] upc, logic ub,
                                logic [31:0] bpc, logic [31:0] jmp, logic tk,
                                logic [31:0] epc, logic ev, logic etk, logic [31:0] etgt);
        vec_t v;
        v.pc_en = en;  v.modify = md;  v.upd_pc = upc;  v.upd_btb = ub;
        v.btb_pc = bpc; v.jump = jmp;  v.taken = tk;
        v.exp_pc = epc; v.exp_valid = ev; v.exp_tk = etk; v.exp_tgt = etgt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive(logic en, logic md, logic [31:0] upc, logic ub,
                         logic [31:0] bpc, logic [31:0] jmp, logic tk);
        bus.pc_en = en;  bus.modify_pc_ex = md;  bus.update_pc_ex = upc;
        bus.update_btb_ex = ub; bus.btb_pc_ex = bpc; bus.jump_addr_ex = jmp;
        bus.ex_branch_taken = tk;
    endtask

    task automatic check_outs(string tag, logic [31:0] epc, logic ev, logic etk,
                              logic [31:0] etgt);
        logic [31:0] eaddr;
        eaddr = {22'b0, epc[11:2]};
        check({tag, " pc_if"}, bus.pc_if, epc);
        check({tag, " valid_if"}, {31'b0, bus.valid_if}, {31'b0, ev});
        check({tag, " pred_taken"}, {31'b0, bus.predictedTaken_if}, {31'b0, etk});
        check({tag, " pred_target"}, bus.predictedTarget_if, etgt);
        check({tag, " imem_addr"}, {22'b0, bus.imem_addr}, eaddr);
        check({tag, " instr_if"}, bus.instr_if, 32'hA500_0000 | eaddr);
    endtask

    initial begin
        //          en md upd_pc        ub btb_pc      jump          tk  exp_pc        ev etk exp_tgt
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h0,        0, 0, 32'h4));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h4,        1, 0, 32'h8));
        vq.push_back(mk(1, 0, 32'h0,       1, 32'h10,  32'h40,  1,  32'h8,        1, 0, 32'hC));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'hC,        1, 0, 32'h10));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h10,       1, 1, 32'h40));
        vq.push_back(mk(1, 0, 32'h0,       1, 32'h10,  32'h0,   0,  32'h40,       1, 0, 32'h44));
        vq.push_back(mk(1, 1, 32'h10,      0, 32'h0,   32'h0,   0,  32'h44,       0, 0, 32'h48));
        vq.push_back(mk(1, 0, 32'h0,       1, 32'h10,  32'h40,  1,  32'h10,       1, 0, 32'h14));
        vq.push_back(mk(1, 0, 32'h0,       1, 32'h10,  32'h40,  1,  32'h14,       1, 0, 32'h18));
        vq.push_back(mk(1, 0, 32'h0,       1, 32'h10,  32'h40,  1,  32'h18,       1, 0, 32'h1C));
        vq.push_back(mk(1, 0, 32'h0,       1, 32'h10,  32'h0,   0,  32'h1C,       1, 0, 32'h20));
        vq.push_back(mk(1, 1, 32'h10,      0, 32'h0,   32'h0,   0,  32'h20,       0, 0, 32'h24));
        vq.push_back(mk(1, 0, 32'h0,       1, 32'h50,  32'h82,  1,  32'h10,       1, 1, 32'h40));
        vq.push_back(mk(1, 1, 32'h10,      0, 32'h0,   32'h0,   0,  32'h40,       0, 0, 32'h44));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h10,       1, 0, 32'h14));
        vq.push_back(mk(1, 1, 32'h50,      0, 32'h0,   32'h0,   0,  32'h14,       0, 0, 32'h18));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h50,       1, 1, 32'h80));
        vq.push_back(mk(0, 1, 32'h200,     0, 32'h0,   32'h0,   0,  32'h80,       0, 0, 32'h84));
        vq.push_back(mk(0, 0, 32'h0,       1, 32'h300, 32'h120, 1,  32'h200,      1, 0, 32'h204));
        vq.push_back(mk(0, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h200,      1, 0, 32'h204));
        vq.push_back(mk(0, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h200,      1, 0, 32'h204));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h200,      1, 0, 32'h204));
        vq.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0,   0,  32'h204,      0, 0, 32'h208));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'hFFFF_FFFC, 1, 0, 32'h0));
        vq.push_back(mk(1, 1, 32'h300,     0, 32'h0,   32'h0,   0,  32'h0,        0, 0, 32'h4));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h300,      1, 1, 32'h120));
        vq.push_back(mk(1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  32'h120,      1, 0, 32'h124));

        drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        #1;
        check_outs("in_reset", 32'h0, 0, 0, 32'h4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].pc_en, vq[i].modify, vq[i].upd_pc, vq[i].upd_btb,
                  vq[i].btb_pc, vq[i].jump, vq[i].taken);
            #1;
            check_outs($sformatf("vec%0d", i), vq[i].exp_pc, vq[i].exp_valid,
                       vq[i].exp_tk, vq[i].exp_tgt);
        end

        // Mid-run reset with a training update in flight that must be dropped.
        @(negedge clk);
        drive(1, 0, 32'h0, 1, 32'h400, 32'h500, 1);
        #2 rst = 1'b0;
        #1;
        check_outs("midrst", 32'h0, 0, 0, 32'h4);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        rst = 1'b1;
        #1;
        check_outs("rst_rel", 32'h0, 0, 0, 32'h4);
        @(negedge clk);
        drive(1, 1, 32'h50, 0, 32'h0, 32'h0, 0);
        #1;
        check_outs("post_rst", 32'h4, 0, 0, 32'h8);
        @(negedge clk);
        drive(1, 1, 32'h300, 0, 32'h0, 32'h0, 0);
        #1;
        check_outs("cleared_50", 32'h50, 0, 0, 32'h54);
        @(negedge clk);
        drive(1, 1, 32'h400, 0, 32'h0, 32'h0, 0);
        #1;
        check_outs("cleared_300", 32'h300, 0, 0, 32'h304);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        #1;
        check_outs("dropped_400", 32'h400, 1, 0, 32'h404);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/if_stage_btb_param.md
Name: if_stage_btb_param

Overview:
Parametrised instruction-fetch stage with an internal direct-mapped branch target buffer (BTB). Each BTB entry holds a valid bit, a tag, a target and an N-bit saturating direction counter. The block holds the PC register, performs the BTB lookup and next-PC selection, and drives the combinational instruction-memory read. It feeds the IF/ID register. The branch PC used for BTB training is a separate port from the redirect target.

Parameters:
XLEN, 32, PC/data width
BTB_ENTRIES, 16, BTB depth; power of two, >=2
CTR_BITS, 2, direction counter width, >=1
RESET_PC, 32'h0000_0000, PC after reset
IMEM_ADDR_W, 10, word-address width to instruction memory

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pc_en  in  1  1 = PC may advance; 0 = hazard stall, hold PC
modify_pc_ex  in  1  EX redirect (mispredict or jump)
update_pc_ex  in  XLEN  redirect target PC
update_btb_ex  in  1  train BTB this cycle
btb_pc_ex  in  XLEN  PC of the resolved branch being trained
jump_addr_ex  in  XLEN  resolved branch target
ex_branch_taken  in  1  resolved direction
imem_addr  out  IMEM_ADDR_W  = pc_if[IMEM_ADDR_W+1:2]
imem_rdata  in  32  combinational instruction read data
pc_if  out  XLEN  current fetch PC
instr_if  out  32  = imem_rdata
valid_if  out  1  IF slot holds a correct-path instruction
predictedTaken_if  out  1  BTB hit and counter MSB = 1
predictedTarget_if  out  XLEN  BTB target if predicted taken, else pc_if+4

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_if = RESET_PC.
  - All BTB valid bits = 0; all counters = 0; valid_if = 0.
- valid_if:
  - Registered. Becomes 1 on the first rising edge after rst deasserts.
  - Combinationally forced to 0 in any cycle with modify_pc_ex = 1 (wrong-path slot).
- Index and tag, with IDX = log2(BTB_ENTRIES):
  - index = pc[IDX+1:2]
  - tag = pc[XLEN-1:IDX+2]
- Lookup (combinational on pc_if):
  - hit = valid[index] && tag match.
  - predictedTaken_if = hit && ctr[CTR_BITS-1].
- next_pc priority:
  1. modify_pc_ex -> update_pc_ex. This overrides a stall: a redirect loads even when pc_en = 0.
  2. pc_en = 0 -> hold.
  3. predictedTaken_if -> stored target.
  4. Otherwise pc_if + 4, modulo 2^XLEN (wraps at the top of the address space).
- PC register loads on the rising edge. Bits [1:0] of every loaded PC are forced to 0.
- BTB update on the rising edge when update_btb_ex = 1, indexed and tagged by btb_pc_ex:
  - Hit, taken: counter increments, saturating at 2^CTR_BITS-1; target is written with jump_addr_ex with [1:0] = 0.
  - Hit, not taken: counter decrements, saturating at 0; target unchanged.
  - Miss, taken: entry is allocated or overwritten. valid = 1, new tag, new target, counter = 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no change.
- Update is not gated by pc_en.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents; the new contents are visible on the next cycle.
- instr_if and imem_addr are pure combinational functions of pc_if; fetch latency is 0 cycles.
- Reset asserted mid-operation: immediate return to the reset state. Any in-flight update is discarded.

Test Plan:
1. Reset, then rst=1, pc_en=1, no updates, RESET_PC=0:
   - pc_if goes 0,4,8,C; imem_addr 0,1,2,3; valid_if=0 before the first edge, 1 after; predictedTaken_if=0.
2. Training:
   - Train btb_pc_ex=0x10, jump_addr_ex=0x40, taken=1, once.
   - When pc_if reaches 0x10: predictedTaken_if=1, predictedTarget_if=0x40, next pc_if=0x40.
3. Counter walk, CTR_BITS=2, same 0x10 entry:
   - One not-taken update -> ctr=1, predictedTaken_if=0 at 0x10.
   - Three taken updates -> ctr saturates at 3.
   - A further taken update leaves ctr=3.
4. Aliasing, BTB_ENTRIES=16:
   - Train 0x10 taken to 0x40, then 0x50 taken to 0x80 (same index, different tag).
   - At pc 0x10: predictedTaken_if=0, next pc 0x14.
   - At pc 0x50: next pc 0x80.
5. Redirect during stall:
   - pc_en=0 and modify_pc_ex=1 with update_pc_ex=0x200 -> pc_if=0x200 next cycle; valid_if=0 during the redirect cycle.
   - pc_en=0 alone holds pc_if for 3 cycles.
6. Corner cases:
   - pc_if=0xFFFF_FFFC, no prediction -> next pc_if=0x0.
   - rst asserted mid-run -> pc_if=RESET_PC immediately; previously trained PCs no longer predict.
